// File: rtl/regfile_dump_ctrl.sv
// Debug register-file dump sequencer: walks x0..x(NUM_REGS-1) and streams each word
// as little-endian bytes. Optional trailing XOR checksum byte under REGDUMP_CHECKSUM_EN.
module regfile_dump_ctrl #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [4:0]            dbg_addr_o,
    input  logic [DATA_WIDTH-1:0] dbg_data_i,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic                  halt_req_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SEND, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SEND, S_DONE} state_t;
`endif

    state_t                  state_q, state_d;
    logic [4:0]              reg_idx_q;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [BCW-1:0]          byte_cnt_q;
    logic                    last_byte, last_reg;
`ifdef REGDUMP_CHECKSUM_EN
    logic [7:0]              csum_q;
`endif

    assign last_byte = (byte_cnt_q == BCW'(BYTES - 1));
    assign last_reg  = (reg_idx_q == 5'(NUM_REGS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_LATCH;
            S_LATCH: state_d = S_SEND;
            S_SEND: begin
                if (tx_ready_i && last_byte) begin
`ifdef REGDUMP_CHECKSUM_EN
                    state_d = last_reg ? S_CSUM : S_LATCH;
`else
                    state_d = last_reg ? S_DONE : S_LATCH;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM:  if (tx_ready_i) state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort outranks every transition once a dump is under way.
        if (state_q != S_IDLE && abort_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_idx_q  <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        reg_idx_q <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_q    <= '0;
`endif
                    end
                end
                S_LATCH: begin
                    word_q     <= dbg_data_i;
                    byte_cnt_q <= '0;
                end
                S_SEND: begin
                    if (tx_ready_i) begin
                        word_q     <= word_q >> 8;
                        byte_cnt_q <= BCW'(byte_cnt_q + 1'b1);
`ifdef REGDUMP_CHECKSUM_EN
                        csum_q     <= csum_q ^ word_q[7:0];
`endif
                        if (last_byte && !last_reg) reg_idx_q <= reg_idx_q + 5'd1;
                    end
                end
                S_DONE:  reg_idx_q <= '0;
                default: ;
            endcase
            if (state_q != S_IDLE && abort_i) reg_idx_q <= '0;
        end
    end

    // Outputs decode registers only; the index register drives the read port directly.
    always_comb begin
        dbg_addr_o = reg_idx_q;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        busy_o     = (state_q != S_IDLE);
        halt_req_o = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
        if (state_q == S_SEND) begin
            tx_valid_o = 1'b1;
            tx_data_o  = word_q[7:0];
        end
`ifdef REGDUMP_CHECKSUM_EN
        if (state_q == S_CSUM) begin
            tx_valid_o = 1'b1;
            tx_data_o  = csum_q;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Randomized self-checking bench for regfile_dump_ctrl; expected byte stream is built
// from a register-file array, and stream/timing rules are checked every cycle.
module tb_regfile_dump_ctrl;

    localparam int NREG = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int EXP_N    = NREG * 4 + 1;
    localparam int DONE_CYC = 162;
`else
    localparam int EXP_N    = NREG * 4;
    localparam int DONE_CYC = 161;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        halt_req;
    logic        busy;
    logic        done;

    logic [31:0] rf [NREG];
    logic [7:0]  exp_q [$];

    int   total = 0;
    int   bad = 0;
    int   rx_cnt = 0;
    int   done_cnt = 0;
    int   base = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    assign dbg_data = rf[dbg_addr];

    regfile_dump_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .abort_i    (abort),
        .dbg_addr_o (dbg_addr),
        .dbg_data_i (dbg_data),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (tx_ready),
        .halt_req_o (halt_req),
        .busy_o     (busy),
        .done_o     (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream: every register little-endian, optionally followed by the XOR of all bytes.
    task automatic build_exp();
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int r = 0; r < NREG; r++)
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(8'((rf[r] >> (8 * b)) & 32'hFF));
                x = x ^ 8'((rf[r] >> (8 * b)) & 32'hFF);
            end
`ifdef REGDUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < NREG; r++) rf[r] = (r == 0) ? 32'h0 : 32'h11223300 + r;
    endtask

    task automatic monitor();
        int idx;
        if (!rst_n) begin
            prev_stall = 1'b0;
            return;
        end
        idx = rx_cnt - base;
        if (tx_valid && tx_ready) begin
            if (idx < exp_q.size()) check("stream_byte", 64'(tx_data), 64'(exp_q[idx]));
            else check("extra_byte", 64'(idx), 64'(exp_q.size()));
            rx_cnt++;
        end
        if (prev_stall) check("stall_stable", {tx_valid, tx_data}, {1'b1, prev_data});
        prev_stall = tx_valid && !tx_ready && !abort;
        prev_data  = tx_data;
        if (done) begin
            done_cnt++;
            check("done_all_bytes", 64'(rx_cnt - base), 64'(exp_q.size()));
        end
    endtask

    // One cycle: observe at negedge, then return 1 time unit after the posedge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_dump(input int pct, input int extra_start, output int done_cyc);
        int  dbase;
        logic halt_ok;
        dbase    = done_cnt;
        base     = rx_cnt;
        done_cyc = -1;
        halt_ok  = 1'b1;
        check("idle_before_start", {busy, halt_req}, 2'b00);
        start    = 1'b1;
        tx_ready = ($urandom_range(0, 99) < pct);
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 8000; cyc++) begin
            start    = (cyc == extra_start);
            tx_ready = ($urandom_range(0, 99) < pct);
            if (!(halt_req && busy)) halt_ok = 1'b0;
            if (done) done_cyc = cyc;
            tick();
            if (done_cyc >= 0) break;
        end
        start = 1'b0;
        check("dump_finished", 64'(done_cyc >= 0), 64'd1);
        check("halt_held", 64'(halt_ok), 64'd1);
        check("idle_after_done", {busy, halt_req, tx_valid, done}, 4'b0000);
        check("byte_count", 64'(rx_cnt - base), 64'(exp_q.size()));
        check("done_pulses", 64'(done_cnt - dbase), 64'd1);
    endtask

    initial begin
        int dc;
        int dbase;
        logic aborted;

        fill_pattern();
        build_exp();
        check("model_size", 64'(exp_q.size()), 64'(EXP_N));
        check("model_x0", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}, 32'h0);
        check("model_x1", {exp_q[4], exp_q[5], exp_q[6], exp_q[7]}, 32'h01332211);
        check("model_x31", {exp_q[124], exp_q[127]}, 16'h1F11);

        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("reset_idle", {tx_valid, tx_data, halt_req, busy, done, dbg_addr}, '0);
            tick();
        end

        // Full dump, sink always ready: exact latency.
        run_dump(100, -1, dc);
        check("done_cycle", 64'(dc), 64'(DONE_CYC));

        // Backpressure on the same contents, then random contents.
        run_dump(30, -1, dc);
        for (int r = 1; r < NREG; r++) rf[r] = $urandom;
        build_exp();
        run_dump(40, -1, dc);

        // Abort at the handshake of byte 10.
        fill_pattern();
        build_exp();
        dbase    = done_cnt;
        base     = rx_cnt;
        aborted  = 1'b0;
        start    = 1'b1;
        tx_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            tx_ready = ($urandom_range(0, 99) < 50);
            if (tx_valid && tx_ready && (rx_cnt - base) == 10) begin
                abort = 1'b1;
                tick();
                abort   = 1'b0;
                aborted = 1'b1;
                break;
            end
            tick();
        end
        check("abort_reached", 64'(aborted), 64'd1);
        check("abort_idle", {tx_valid, busy, halt_req, done}, 4'b0000);
        tx_ready = 1'b1;
        repeat (20) tick();
        check("abort_truncated", 64'(rx_cnt - base), 64'd11);
        check("abort_no_done", 64'(done_cnt - dbase), 64'd0);
        run_dump(100, -1, dc);
        check("after_abort_done_cycle", 64'(dc), 64'(DONE_CYC));

        // start_i while busy must be ignored.
        run_dump(100, 50, dc);
        check("start_busy_done_cycle", 64'(dc), 64'(DONE_CYC));

        // Asynchronous reset mid-dump.
        base     = rx_cnt;
        start    = 1'b1;
        tx_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 80; cyc++) tick();
        check("pre_reset_busy", {busy, halt_req}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("async_reset", {tx_valid, tx_data, halt_req, busy, done, dbg_addr}, '0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", {tx_valid, tx_data, halt_req, busy, done, dbg_addr}, '0);

`ifdef REGDUMP_CHECKSUM_EN
        for (int r = 0; r < NREG; r++) rf[r] = (r == 0) ? 32'h0 : 32'hA5A5A5A5;
        build_exp();
        check("csum_model_last", 64'(exp_q[EXP_N-1]), 64'h00);
        run_dump(100, -1, dc);
        check("csum_done_cycle", 64'(dc), 64'(DONE_CYC));
        for (int r = 1; r < NREG; r++) rf[r] = $urandom;
        build_exp();
        run_dump(30, -1, dc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
